// File: rtl/pdm_mic_capture_if.sv
// Sample stream interface: an 8-bit unsigned sample with a valid/ready handshake.
interface pdm_mic_capture_if;
    logic [7:0] sample;
    logic       sample_valid;
    logic       sample_ready;

    modport master (output sample, output sample_valid, input sample_ready);
    modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/pdm_mic_capture.sv
// PDM microphone capture: generates M_CLK, samples the 1-bit stream once per
// M_CLK period and decimates it by ones-counting into 8-bit unsigned samples.
module pdm_mic_capture #(
    parameter int CLK_DIV = 50,   // clk cycles per M_CLK half-period, 1..255
    parameter int DECIM   = 128,  // PDM bits per output sample, power of two 2..256
    parameter bit LR_SEL  = 1'b0  // channel select; also picks the sample phase
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       M_DATA,
    output logic                       M_CLK,
    output logic                       M_LRSEL,
    output logic                       overrun,
    pdm_mic_capture_if.master          sample_if
);

    localparam int SCALE = 256 / DECIM;

    logic [7:0] div_cnt_reg;
    logic       m_clk_reg;
    logic       sync1_reg, sync2_reg;
    logic [8:0] acc_reg;
    logic [8:0] bit_cnt_reg;
    logic [7:0] sample_reg;
    logic       sample_valid_reg;
    logic       overrun_reg;

    logic        div_wrap;
    logic        sample_event;
    logic        last_bit;
    logic        load;
    logic [8:0]  total;
    logic [16:0] scaled;
    logic [7:0]  result;

    assign div_wrap = (div_cnt_reg == 8'(CLK_DIV - 1));
    // LR_SEL=0 samples at the end of the high phase, LR_SEL=1 at the end of the low phase.
    assign sample_event = en && div_wrap && (m_clk_reg == ~LR_SEL);
    assign last_bit     = (bit_cnt_reg == 9'(DECIM - 1));
    assign load         = sample_event && last_bit;

    // Window total includes the bit arriving on the final event; all-ones saturates to 255.
    assign total  = acc_reg + {8'd0, sync2_reg};
    assign scaled = 17'(total) * 17'(SCALE);
    assign result = (scaled > 17'd255) ? 8'hFF : scaled[7:0];

    // Two-flop synchroniser for the asynchronous PDM data line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= M_DATA;
            sync2_reg <= sync1_reg;
        end
    end

    // Clock divider: M_CLK toggles every CLK_DIV cycles, held low while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= 8'd0;
            m_clk_reg   <= 1'b0;
        end else if (!en) begin
            div_cnt_reg <= 8'd0;
            m_clk_reg   <= 1'b0;
        end else if (div_wrap) begin
            div_cnt_reg <= 8'd0;
            m_clk_reg   <= ~m_clk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
        end
    end

    // Ones-counting accumulator; restarts each window and whenever capture is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg     <= 9'd0;
            bit_cnt_reg <= 9'd0;
        end else if (!en) begin
            acc_reg     <= 9'd0;
            bit_cnt_reg <= 9'd0;
        end else if (sample_event) begin
            if (last_bit) begin
                acc_reg     <= 9'd0;
                bit_cnt_reg <= 9'd0;
            end else begin
                acc_reg     <= total;
                bit_cnt_reg <= bit_cnt_reg + 9'd1;
            end
        end
    end

    // Output register and handshake; a load always wins, overwriting unconsumed data flags overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_reg       <= 8'd0;
            sample_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            if (load) begin
                sample_reg       <= result;
                sample_valid_reg <= 1'b1;
                if (sample_valid_reg && !sample_if.sample_ready)
                    overrun_reg <= 1'b1;
            end else if (sample_valid_reg && sample_if.sample_ready) begin
                sample_valid_reg <= 1'b0;
            end
            // Disabling capture clears the sticky flag but keeps any pending sample.
            if (!en)
                overrun_reg <= 1'b0;
        end
    end

    assign M_CLK                  = m_clk_reg;
    assign M_LRSEL                = LR_SEL;
    assign overrun                = overrun_reg;
    assign sample_if.sample       = sample_reg;
    assign sample_if.sample_valid = sample_valid_reg;

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Directed bench for pdm_mic_capture: instance A (CLK_DIV=4, DECIM=128, LR_SEL=0)
// and instance B (CLK_DIV=2, DECIM=64, LR_SEL=1). Edge counts are relative to
// the edge after which capture was enabled or reset released.
module tb_pdm_mic_capture;

    logic clk = 1'b0;
    logic rst_n;
    logic en_a, m_data_a, m_clk_a, lrsel_a, overrun_a;
    logic en_b, m_data_b, m_clk_b, lrsel_b, overrun_b;
    logic alt_a = 1'b0;
    logic pat_b = 1'b0;
    int   pat_cnt = 0;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    pdm_mic_capture_if ia ();
    pdm_mic_capture_if ib ();

    pdm_mic_capture #(.CLK_DIV(4), .DECIM(128), .LR_SEL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .M_DATA(m_data_a),
        .M_CLK(m_clk_a), .M_LRSEL(lrsel_a), .overrun(overrun_a), .sample_if(ia)
    );

    pdm_mic_capture #(.CLK_DIV(2), .DECIM(64), .LR_SEL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .M_DATA(m_data_b),
        .M_CLK(m_clk_b), .M_LRSEL(lrsel_b), .overrun(overrun_b), .sample_if(ib)
    );

    always #5 clk = ~clk;

    // Alternating 1/0 pattern on A, one bit per M_CLK period.
    initial begin
        forever begin
            @(posedge m_clk_a);
            if (alt_a) m_data_a = ~m_data_a;
        end
    end

    // One-in-four pattern on B (16 ones per 64 bits).
    initial begin
        forever begin
            @(posedge m_clk_b);
            if (pat_b) begin
                m_data_b = (pat_cnt == 0);
                pat_cnt  = (pat_cnt + 1) % 4;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        en_a = 1'b0; m_data_a = 1'b1; ia.sample_ready = 1'b1;
        en_b = 1'b0; m_data_b = 1'b1; ib.sample_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_mclk",    32'(m_clk_a), 0);
        chk("rst_sample",  32'(ia.sample), 0);
        chk("rst_valid",   32'(ia.sample_valid), 0);
        chk("rst_overrun", 32'(overrun_a), 0);
        chk("lrsel_a",     32'(lrsel_a), 0);
        chk("lrsel_b",     32'(lrsel_b), 1);

        rst_n = 1'b1; en_a = 1'b1; cyc = 0;
        // M_CLK toggles every CLK_DIV clocks
        tick_to(3);    chk("mclk_c3", 32'(m_clk_a), 0);
        tick_to(4);    chk("mclk_c4", 32'(m_clk_a), 1);
        tick_to(8);    chk("mclk_c8", 32'(m_clk_a), 0);
        // First sample after exactly 128 M_CLK periods, all ones saturates
        tick_to(1023); chk("first_valid_early", 32'(ia.sample_valid), 0);
        tick_to(1024); chk("first_valid", 32'(ia.sample_valid), 1);
                       chk("ones_sample", 32'(ia.sample), 32'hFF);
        m_data_a = 1'b0;
        tick_to(1025); chk("xfer_valid", 32'(ia.sample_valid), 0);
        // All zeros
        tick_to(2048); chk("zeros_valid", 32'(ia.sample_valid), 1);
                       chk("zeros_sample", 32'(ia.sample), 0);
        alt_a = 1'b1;
        // Alternating
        tick_to(3072); chk("alt_valid", 32'(ia.sample_valid), 1);
                       chk("alt_sample", 32'(ia.sample), 32'h80);
        alt_a = 1'b0; m_data_a = 1'b1;
        tick_to(3073); chk("alt_xfer", 32'(ia.sample_valid), 0);
        ia.sample_ready = 1'b0;
        // Simultaneous load and transfer
        tick_to(4096); chk("sim_first", 32'(ia.sample), 32'hFF);
        m_data_a = 1'b0;
        tick_to(5119); chk("sim_hold_valid", 32'(ia.sample_valid), 1);
                       chk("sim_hold_sample", 32'(ia.sample), 32'hFF);
        ia.sample_ready = 1'b1;
        tick_to(5120); chk("sim_new_sample", 32'(ia.sample), 0);
                       chk("sim_valid", 32'(ia.sample_valid), 1);
                       chk("sim_overrun", 32'(overrun_a), 0);
        ia.sample_ready = 1'b0; alt_a = 1'b1;
        // Overrun
        tick_to(6143); chk("ovr_hold_sample", 32'(ia.sample), 0);
                       chk("ovr_before", 32'(overrun_a), 0);
        tick_to(6144); chk("ovr_sample", 32'(ia.sample), 32'h80);
                       chk("ovr_valid", 32'(ia.sample_valid), 1);
                       chk("ovr_set", 32'(overrun_a), 1);
        alt_a = 1'b0; m_data_a = 1'b1; ia.sample_ready = 1'b1;
        tick_to(6145); chk("ovr_xfer_valid", 32'(ia.sample_valid), 0);
                       chk("ovr_sticky", 32'(overrun_a), 1);
        ia.sample_ready = 1'b0;
        // en=0 mid-window with pending sample
        tick_to(7168); chk("pend_sample", 32'(ia.sample), 32'hFF);
        tick_to(7468); chk("pre_dis_mclk", 32'(m_clk_a), 1);
                       chk("pre_dis_overrun", 32'(overrun_a), 1);
        en_a = 1'b0;
        tick_to(7469); chk("dis_mclk", 32'(m_clk_a), 0);
                       chk("dis_overrun", 32'(overrun_a), 0);
                       chk("dis_valid", 32'(ia.sample_valid), 1);
                       chk("dis_sample", 32'(ia.sample), 32'hFF);
        tick_to(7490); chk("dis_valid_late", 32'(ia.sample_valid), 1);
        ia.sample_ready = 1'b1;
        tick_to(7491); chk("dis_drain", 32'(ia.sample_valid), 0);
        ia.sample_ready = 1'b0;
        // Re-enable: fresh window
        en_a = 1'b1; cyc = 0;
        tick_to(1023); chk("reen_early", 32'(ia.sample_valid), 0);
        tick_to(1024); chk("reen_valid", 32'(ia.sample_valid), 1);
                       chk("reen_sample", 32'(ia.sample), 32'hFF);
        // Reset mid-window at bit 60
        tick_to(1508); chk("prerst_mclk", 32'(m_clk_a), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_mclk",    32'(m_clk_a), 0);
        chk("arst_sample",  32'(ia.sample), 0);
        chk("arst_valid",   32'(ia.sample_valid), 0);
        chk("arst_overrun", 32'(overrun_a), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; ia.sample_ready = 1'b1; cyc = 0;
        tick_to(1023); chk("postrst_early", 32'(ia.sample_valid), 0);
        tick_to(1024); chk("postrst_valid", 32'(ia.sample_valid), 1);
                       chk("postrst_sample", 32'(ia.sample), 32'hFF);
                       chk("postrst_overrun", 32'(overrun_a), 0);
        // Instance B: DECIM=64, LR_SEL=1
        en_b = 1'b1; cyc = 0;
        tick_to(253);  chk("b_early", 32'(ib.sample_valid), 0);
        tick_to(254);  chk("b_valid", 32'(ib.sample_valid), 1);
                       chk("b_ones", 32'(ib.sample), 32'hFF);
        m_data_b = 1'b0; pat_b = 1'b1;
        tick_to(255);  chk("b_xfer", 32'(ib.sample_valid), 0);
        tick_to(509);  chk("b_pat_early", 32'(ib.sample_valid), 0);
        tick_to(510);  chk("b_pat_valid", 32'(ib.sample_valid), 1);
                       chk("b_pat_sample", 32'(ib.sample), 32'h40);
                       chk("b_overrun", 32'(overrun_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pdm_mic_capture.md
Name: pdm_mic_capture

Overview:
- Audio input path; the receive-side counterpart of the PWM audio output stage.
- Generates the PDM microphone clock from the 100 MHz system clock and samples the 1-bit PDM stream.
- Decimates the stream by ones-counting over a fixed window into 8-bit unsigned samples, the same format the message, modulator and audio paths use.
- Presents samples on a valid/ready interface so they can replace the wave generator as the message source.

Parameters:
- CLK_DIV, 50, system clocks per M_CLK half-period (50 -> 1 MHz M_CLK); legal range 1..255
- DECIM, 128, PDM bits per output sample; power of two, 2..256
- LR_SEL, 0, value driven on M_LRSEL; also selects the sample phase

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable
- M_DATA  input  1  PDM data from microphone (asynchronous to clk)
- M_CLK  output  1  microphone clock
- M_LRSEL  output  1  channel select, constant LR_SEL
- sample  output  8  unsigned decimated sample
- sample_valid  output  1  sample holds unconsumed data
- sample_ready  input  1  consumer accepts sample
- overrun  output  1  sticky: an unconsumed sample was overwritten

Behaviour:
- Reset (async, rst_n=0) clears all state:
  - M_CLK=0, sample=0, sample_valid=0, overrun=0.
  - Divider, bit counter and accumulator are all cleared.
  - M_LRSEL=LR_SEL at all times.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while en=1.
  - At CLK_DIV-1, div_cnt wraps to 0 and M_CLK toggles, so the M_CLK period is 2*CLK_DIV clk cycles.
- M_DATA synchronisation: two-flop synchroniser, giving 2 clk of latency.
- Sample event:
  - LR_SEL=0: the clk cycle where div_cnt=CLK_DIV-1 and M_CLK=1 (last cycle of the high phase).
  - LR_SEL=1: the same cycle with M_CLK=0.
  - Exactly one sample event per M_CLK period.
- Accumulation, on each sample event:
  - acc += synchronised bit; bit_cnt increments.
  - On the event where bit_cnt=DECIM-1:
    - total = acc + bit, range 0..DECIM.
    - Result = min(total * (256/DECIM), 255).
    - acc and bit_cnt clear in the same cycle.
- Output load:
  - Result registers into sample with sample_valid=1 on the clk edge ending the final sample event.
  - Latency from that event is 1 clk.
- Handshake:
  - Transfer occurs on a clk edge with sample_valid=1 and sample_ready=1; sample_valid drops after it unless a load coincides.
  - sample is stable while sample_valid=1 and no load occurs.
  - sample_ready with sample_valid=0 has no effect.
- Simultaneous load and transfer: the new sample is loaded, sample_valid stays 1, and overrun is not set.
- Overrun:
  - Triggered by a load while sample_valid=1 and sample_ready=0.
  - The new sample overwrites the old one and overrun is set.
  - overrun clears only on reset or when en goes low.
- en=0:
  - M_CLK is forced 0 on the next clk; div_cnt, bit_cnt, acc and overrun clear.
  - A pending sample/sample_valid is retained and still drainable.
- Re-enable: the first window starts fresh, and the first sample appears after exactly DECIM M_CLK periods.
- Reset mid-window: the partial window is discarded and no sample is emitted.

Test Plan:
1. CLK_DIV=50, en=1 -> M_CLK toggles every 50 clk (100-clk period, 1 MHz); M_LRSEL=0; first sample_valid after 128 M_CLK periods.
2. M_DATA held 1, sample_ready=1 -> every sample=255 (total 128 saturates); M_DATA held 0 -> sample=0; M_DATA alternating 1/0 per M_CLK period -> sample=128.
3. sample_ready=0 across two windows -> first sample (e.g. 0x80) held stable until overwritten, then overrun=1; later sample_ready=1 -> transfer, sample_valid=0, overrun stays 1.
4. Pulse sample_ready exactly on the load cycle with sample_valid=1 -> new sample visible, sample_valid stays 1, overrun stays 0.
5. Deassert rst_n at bit 60 of a window with M_DATA=1 -> all outputs 0 immediately; after release, next sample follows a full 128-bit window and equals 255.
6. en=0 mid-window with a pending sample -> M_CLK=0, overrun=0, sample_valid retained until accepted; re-enable with M_DATA=1 -> next sample=255 after 128 M_CLK periods; DECIM=64 build with all-ones -> 255, with 16 ones per 64 bits -> 64.
